// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte stream, assembles
// little-endian 32-bit words, writes them to instruction memory and
// verifies an XOR checksum before releasing the core from reset.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_wr_en_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wr_data_o,
  output logic        cpu_reset_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [23:0] asm_q, asm_d;        // lanes 0..2; lane 3 comes straight from the input
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        accept;
  logic [15:0] len_rx;

  assign byte_ready_o   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                          (state_q == S_CSUM)   || ((state_q == S_DATA) && !wr_q);
  assign accept         = byte_valid_i && byte_ready_o;
  assign len_rx         = {len_q[15:8], byte_data_i};
  assign imem_wr_en_o   = wr_q;
  assign imem_addr_o    = addr_q;
  assign imem_wr_data_o = wdata_q;
  assign cpu_reset_o    = (state_q != S_DONE);
  assign done_o         = (state_q == S_DONE);
  assign err_o          = (state_q == S_ERR);

  // Next-state logic: stream parsing, word assembly and write scheduling.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    asm_d      = asm_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_LEN_HI;
          word_idx_d = '0;
          byte_idx_d = '0;
          csum_d     = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {byte_data_i, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = len_rx;
          if (len_rx == 16'd0)                       state_d = S_CSUM;
          else if (32'(len_rx) > 32'(MAX_WORDS))     state_d = S_ERR;
          else                                       state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (wr_q) begin
          // Write cycle: advance to the next word, or finish after the last one.
          word_idx_d = word_idx_q + 16'd1;
          if (word_idx_q == len_q - 16'd1) state_d = S_CSUM;
        end else if (accept) begin
          csum_d     = csum_q ^ byte_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = byte_data_i;
            2'd1: asm_d[15:8]  = byte_data_i;
            2'd2: asm_d[23:16] = byte_data_i;
            default: begin
              wr_d    = 1'b1;
              addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
              wdata_d = {byte_data_i, asm_q};
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept) state_d = (byte_data_i == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops any pending write and clears the write bus.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      asm_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      asm_q      <= asm_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (BASE_ADDR 0 and 0x400) share one
// byte stream; expected writes are queued as words are sent and checked
// against both instances when they strobe imem_wr_en_o.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;

  logic        ready_a, wr_a, cpurst_a, done_a, err_a;
  logic [31:0] addr_a, data_a;
  logic        ready_b, wr_b, cpurst_b, done_b, err_b;
  logic [31:0] addr_b, data_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] off;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [31:0] prog [3] = '{32'h2000_0013, 32'h0800_0004, 32'hCAFE_F00D};

  always #5 clk = ~clk;

  prog_loader u_dut_a (
    .clk(clk), .reset(reset), .start_i(start_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(ready_a), .imem_wr_en_o(wr_a), .imem_addr_o(addr_a),
    .imem_wr_data_o(data_a), .cpu_reset_o(cpurst_a), .done_o(done_a), .err_o(err_a)
  );

  prog_loader #(.BASE_ADDR(32'h0000_0400), .MAX_WORDS(1024)) u_dut_b (
    .clk(clk), .reset(reset), .start_i(start_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(ready_b), .imem_wr_en_o(wr_b), .imem_addr_o(addr_b),
    .imem_wr_data_o(data_b), .cpu_reset_o(cpurst_b), .done_o(done_b), .err_o(err_b)
  );

  // Scoreboard: every write strobe pops one expected entry.
  always @(negedge clk) begin
    if (wr_a === 1'b1 || wr_b === 1'b1) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: a=%b@%h b=%b@%h, required no write", wr_a, addr_a, wr_b, addr_b);
      end else begin
        e = exp_q.pop_front();
        if (wr_a !== 1'b1 || addr_a !== e.off || data_a !== e.data ||
            wr_b !== 1'b1 || addr_b !== (32'h400 + e.off) || data_b !== e.data) begin
          errors++;
          $display("FAIL write: a=%b %h/%h b=%b %h/%h, required %h/%h and %h/%h",
                   wr_a, addr_a, data_a, wr_b, addr_b, data_b,
                   e.off, e.data, 32'h400 + e.off, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int n = 0;
    int gap = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
    repeat (gap) @(negedge clk);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    while (ready_a !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte_ready_o=%b after %0d cycles, required 1", ready_a, n);
    end else begin
      @(negedge clk);
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] off, input int gapmax);
    exp_q.push_back('{off, w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gapmax);
  endtask

  function automatic logic [7:0] xsum(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) x = x ^ prog[i][8*j +: 8];
    return x;
  endfunction

  task automatic load_main(input logic [7:0] csum);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(prog[0], 32'h0, 0);
    send_word(prog[1], 32'h4, 0);
    send_byte(csum, 0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ready_a, wr_a, cpurst_a, done_a, err_a} !== 5'b00100 || addr_a !== 0 || data_a !== 0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b wr=%b cpurst=%b done=%b err=%b addr=%h data=%h, required 0 0 1 0 0 0 0",
               ready_a, wr_a, cpurst_a, done_a, err_a, addr_a, data_a);
    end
    checks++;
    if ({ready_b, wr_b, cpurst_b, done_b, err_b} !== 5'b00100 || addr_b !== 0 || data_b !== 0) begin
      errors++;
      $display("FAIL reset_outputs_b: rdy=%b wr=%b cpurst=%b addr=%h, required 0 0 1 0", ready_b, wr_b, cpurst_b, addr_b);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_main();
    do_start();
    checks++;
    if (ready_a !== 1'b1 || cpurst_a !== 1'b1) begin
      errors++;
      $display("FAIL main_armed: ready=%b cpurst=%b, required 1 1", ready_a, cpurst_a);
    end
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(prog[0], 32'h0, 0);
    // start_i during DATA must be ignored
    do_start();
    send_word(prog[1], 32'h4, 0);
    send_byte(8'h3F, 0);
    checks++;
    if (done_a !== 1'b1 || cpurst_a !== 1'b0 || err_a !== 1'b0 || ready_a !== 1'b0) begin
      errors++;
      $display("FAIL main_done: done=%b cpurst=%b err=%b ready=%b, required 1 0 0 0", done_a, cpurst_a, err_a, ready_a);
    end
    checks++;
    if (wr_a !== 1'b0 || addr_a !== 32'h4 || data_a !== 32'h0800_0004) begin
      errors++;
      $display("FAIL main_hold: wr=%b addr=%h data=%h, required 0 00000004 08000004", wr_a, addr_a, data_a);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL main_missing_writes: %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_bad_csum();
    do_start();
    checks++;
    if (done_a !== 1'b0 || cpurst_a !== 1'b1) begin
      errors++;
      $display("FAIL rearm: done=%b cpurst=%b, required 0 1", done_a, cpurst_a);
    end
    load_main(8'h00);
    checks++;
    if (err_a !== 1'b1 || done_a !== 1'b0 || cpurst_a !== 1'b1) begin
      errors++;
      $display("FAIL bad_csum: err=%b done=%b cpurst=%b, required 1 0 1", err_a, done_a, cpurst_a);
    end
    do_start();
    checks++;
    if (err_a !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b, required 0", err_a);
    end
    load_main(8'h3F);
    checks++;
    if (done_a !== 1'b1 || cpurst_a !== 1'b0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL reload: done=%b cpurst=%b pending=%0d, required 1 0 0", done_a, cpurst_a, exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if (done_a !== 1'b1 || err_a !== 1'b0 || done_b !== 1'b1) begin
      errors++;
      $display("FAIL zero_len: done=%b err=%b done_b=%b, required 1 0 1", done_a, err_a, done_b);
    end
  endtask

  task automatic test_too_long();
    do_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    checks++;
    if (err_a !== 1'b1 || ready_a !== 1'b0 || cpurst_a !== 1'b1) begin
      errors++;
      $display("FAIL too_long: err=%b ready=%b cpurst=%b, required 1 0 1", err_a, ready_a, cpurst_a);
    end
    byte_valid_i = 1'b1;
    byte_data_i  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ready_a !== 1'b0 || err_a !== 1'b1) begin
        errors++;
        $display("FAIL too_long_idle[%0d]: ready=%b err=%b, required 0 1", i, ready_a, err_a);
      end
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic test_gaps();
    for (int pass = 0; pass < 2; pass++) begin
      int g = (pass == 0) ? 0 : 4;
      do_start();
      send_byte(8'h00, g);
      send_byte(8'h03, g);
      for (int w = 0; w < 3; w++) send_word(prog[w], 32'(4 * w), g);
      send_byte(xsum(3), g);
      checks++;
      if (done_a !== 1'b1 || done_b !== 1'b1 || exp_q.size() !== 0) begin
        errors++;
        $display("FAIL gaps_pass%0d: done=%b done_b=%b pending=%0d, required 1 1 0", pass, done_a, done_b, exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready_a, wr_a, cpurst_a, done_a, err_a} !== 5'b00100 || addr_a !== 0 || data_a !== 0 || addr_b !== 0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b wr=%b cpurst=%b done=%b err=%b addr=%h data=%h addr_b=%h, required 0 0 1 0 0 0 0 0",
               ready_a, wr_a, cpurst_a, done_a, err_a, addr_a, data_a, addr_b);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ready_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b done=%b, required 0 0", ready_a, done_a);
    end
    do_start();
    load_main(8'h3F);
    checks++;
    if (done_a !== 1'b1 || cpurst_a !== 1'b0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL after_reset_load: done=%b cpurst=%b pending=%0d, required 1 0 0", done_a, cpurst_a, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_bad_csum();
    test_zero_len();
    test_too_long();
    test_gaps();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: instruction-memory byte address of program word 0.
REQ-002 Parameter MAX_WORDS, default 1024: largest accepted program length in words.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start_i  input  1  level; begins a load when sampled high in IDLE, DONE or ERR.
REQ-006 byte_valid_i  input  1  source has a byte on byte_data_i.
REQ-007 byte_data_i  input  8  stream byte.
REQ-008 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-009 imem_wr_en_o  output  1  one-cycle instruction-memory write strobe.
REQ-010 imem_addr_o  output  32  write byte address.
REQ-011 imem_wr_data_o  output  32  write word.
REQ-012 cpu_reset_o  output  1  active-high reset to the pipeline core.
REQ-013 done_o  output  1  load completed, checksum good.
REQ-014 err_o  output  1  load aborted (length or checksum error).

Function
REQ-015 A byte is accepted only in a cycle where byte_valid_i and byte_ready_o are both 1; byte_data_i is ignored otherwise.
REQ-016 Stream format: LEN_HI byte, LEN_LO byte (16-bit word count N, big-endian), then N words of 4 bytes each, least-significant byte first, then one checksum byte.
REQ-017 States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
REQ-018 IDLE, DONE, ERR: start_i=1 -> LEN_HI; word index, byte index and checksum accumulator are cleared; done_o and err_o go to 0 on that edge.
REQ-019 LEN_HI -> LEN_LO on an accepted byte. LEN_LO -> DATA on an accepted byte when 0 < N <= MAX_WORDS.
REQ-020 LEN_LO with N = 0 -> CSUM; LEN_LO with N > MAX_WORDS -> ERR.
REQ-021 Checksum = XOR of all accepted DATA bytes only; the length bytes are excluded.
REQ-022 DATA: each accepted byte fills lane byte_index (0..3) of the word assembly register; byte_index wraps 3 -> 0.
REQ-023 The 4th accepted byte of a word drives a write in the next cycle: imem_wr_en_o=1 for exactly one cycle, imem_addr_o = BASE_ADDR + 4*word_index (32-bit, wraps modulo 2^32), imem_wr_data_o = the assembled word.
REQ-024 word_index increments after each write.
REQ-025 After the write of word N-1 the state moves to CSUM; byte_ready_o is 0 in the write cycle, so no byte is accepted while a write is pending.
REQ-026 CSUM: on an accepted byte equal to the accumulator -> DONE; unequal -> ERR.
REQ-027 byte_ready_o = 1 in LEN_HI, LEN_LO, DATA (except the write cycle) and CSUM; 0 otherwise.
REQ-028 cpu_reset_o = 0 only in DONE; 1 in every other state, including immediately after start_i re-arms from DONE.
REQ-029 done_o = 1 only in DONE; err_o = 1 only in ERR.
REQ-030 start_i is ignored in LEN_HI, LEN_LO, DATA and CSUM.
REQ-031 imem_addr_o and imem_wr_data_o hold their last values when imem_wr_en_o = 0.
REQ-032 Stalls: any number of cycles with byte_valid_i = 0 between bytes leaves state and indices unchanged.

Reset
REQ-033 reset = 0 at a clock edge forces IDLE regardless of the current state, including mid-word and mid-write.
REQ-034 Reset values: byte_ready_o=0, imem_wr_en_o=0, imem_addr_o=0, imem_wr_data_o=0, cpu_reset_o=1, done_o=0, err_o=0, all indices and the accumulator 0.
REQ-035 A write pending at reset is dropped and is not issued afterward.

Verification
REQ-036 Bench SHALL cover: start, stream 00 02 | 13 00 00 20 | 04 00 00 08 | checksum 3F -> writes (0x0,0x20000013), (0x4,0x08000004); then DONE, done_o=1, cpu_reset_o=0.
REQ-037 Bench SHALL cover: same stream with checksum 00 -> ERR, err_o=1, cpu_reset_o stays 1; start_i then reloads successfully.
REQ-038 Bench SHALL cover: length 00 00, checksum 00 -> no writes, DONE.
REQ-039 Bench SHALL cover: length 04 01 (1025 > MAX_WORDS) -> ERR after LEN_LO; no bytes accepted afterward.
REQ-040 Bench SHALL cover: random byte_valid_i gaps with BASE_ADDR=32'h400 over 3 words -> addresses 0x400, 0x404, 0x408 and data identical to the gap-free run.
REQ-041 Bench SHALL cover: reset asserted after 2 data bytes -> IDLE, all outputs at reset values, no write issued; a following full load is correct.
